// File: rtl/pe_tile_feeder.sv
// Byte-stream front/back end for single_pe: loads a 3x3 filter and a 4x4 tile, fires the PE,
// waits PE_LATENCY cycles, then drains the 2x2 result as bytes. Optional macro: FILTER_REUSE_EN.
module pe_tile_feeder #(
  parameter int PE_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         fil_reload,
  output logic [71:0]  pe_fil,
  output logic [127:0] pe_in,
  output logic         pe_start,
  input  logic [31:0]  pe_c,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [7:0]   m_data,
  output logic         busy
);

  localparam int CW = (PE_LATENCY > 16) ? $clog2(PE_LATENCY) + 1 : 5;

  typedef enum logic [1:0] {
    ST_LOAD_FIL,
    ST_LOAD_ACT,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   res_buf;
  logic          accept;
  logic          m_xfer;
  logic          start;
  logic          capture;
  logic          loading_next;

  assign accept  = s_valid && s_ready;
  assign m_xfer  = m_valid && m_ready;
  assign start   = (state == ST_LOAD_ACT) && accept && (cnt == CW'(15));
  assign capture = (state == ST_WAIT) && (cnt == CW'(PE_LATENCY - 1));
  assign busy    = !(((state == ST_LOAD_FIL) || (state == ST_LOAD_ACT)) && (cnt == '0));
  assign loading_next = (state_next == ST_LOAD_FIL) || (state_next == ST_LOAD_ACT);

  // One counter serves as load byte index, latency count and drain index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_LOAD_FIL: begin
        if (accept) begin
          if (cnt == CW'(8)) begin
            state_next = ST_LOAD_ACT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ST_LOAD_ACT: begin
        if (accept) begin
          if (cnt == CW'(15)) begin
            state_next = ST_WAIT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (capture) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (m_xfer) begin
          if (cnt == CW'(3)) begin
`ifdef FILTER_REUSE_EN
            state_next = fil_reload ? ST_LOAD_FIL : ST_LOAD_ACT;
`else
            state_next = ST_LOAD_FIL;
`endif
            cnt_next = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_LOAD_FIL;
        cnt_next   = '0;
      end
    endcase
  end

`ifndef FILTER_REUSE_EN
  logic unused_fil_reload;
  assign unused_fil_reload = fil_reload;
`endif

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
    if (!rst) begin
      state    <= ST_LOAD_FIL;
      cnt      <= '0;
      s_ready  <= 1'b0;
      pe_fil   <= '0;
      pe_in    <= '0;
      pe_start <= 1'b0;
      res_buf  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      s_ready  <= loading_next;
      pe_start <= start;

      if (accept && (state == ST_LOAD_FIL)) pe_fil[8*int'(cnt) +: 8] <= s_data;
      if (accept && (state == ST_LOAD_ACT)) pe_in[8*int'(cnt) +: 8]  <= s_data;

      // First result byte is presented straight from pe_c so DRAIN starts without a bubble.
      if (capture) begin
        res_buf <= pe_c;
        m_valid <= 1'b1;
        m_data  <= pe_c[7:0];
      end else if ((state == ST_DRAIN) && m_xfer) begin
        if (cnt == CW'(3)) begin
          m_valid <= 1'b0;
        end else begin
          m_data <= res_buf[8*(int'(cnt) + 1) +: 8];
        end
      end
    end
  end

endmodule
